bitcoin_nonce_sched: RTL and testbench

- Sequences one simplified SHA-256 core through the double-hash Bitcoin flow over a range of nonces.
- Hashes the first header block once to get the midstate. Then, per nonce, hashes the tail block (seeded with the midstate) and hashes that digest again (seeded with the SHA-256 IV).
- Streams out one {nonce, hash word 0} result per nonce over a valid/ready handshake.
- Sits between the top-level bitcoin_hash wrapper and the core; owns the core's start, h_in and block inputs.

---
 rtl/bitcoin_nonce_sched.sv | 177 +++++++++++++++++
 tb/tb_bitcoin_nonce_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_nonce_sched.sv
// bitcoin_nonce_sched: midstate + per-nonce double-hash sequencer for one core.
// Optional early stop on res_hash < target: define BTC_TARGET_STOP_EN.
module bitcoin_nonce_sched #(
  parameter int NUM_NONCES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [18:0][31:0] header,
  input  logic [31:0]       nonce_base,
`ifdef BTC_TARGET_STOP_EN
  input  logic [31:0]       target,
  output logic              hit,
`endif
  output logic              core_start,
  output logic [7:0][31:0]  core_h_in,
  output logic [15:0][31:0] core_block,
  input  logic              core_done,
  input  logic [7:0][31:0]  core_digest,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_nonce,
  output logic [31:0]       res_hash,
  output logic              done
);

  localparam int IW = $clog2(NUM_NONCES + 1);

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    IDLE, MID_ST, MID_WT, P2_ST, P2_WT, P3_ST, P3_WT, EMIT
  } state_t;

  state_t            state;
  logic [18:0][31:0] hdr_q;
  logic [31:0]       base_q;
  logic [IW-1:0]     idx;
  logic              busy_seen;
  logic [7:0][31:0]  mid_q;
  logic [7:0][31:0]  p2_q;
  logic [31:0]       nonce;
  logic [15:0][31:0] p2_blk;
  logic [15:0][31:0] p3_blk;
  logic              core_fin;
  logic              last;
`ifdef BTC_TARGET_STOP_EN
  logic [31:0]       target_q;
  logic              below;

  assign below = res_hash < target_q;
  assign last  = (idx == IW'(NUM_NONCES - 1)) || below;
`else
  assign last  = idx == IW'(NUM_NONCES - 1);
`endif

  assign nonce    = base_q + 32'(idx);
  assign core_fin = core_done && busy_seen;

  always_comb begin
    p2_blk     = '0;
    p2_blk[0]  = hdr_q[16];
    p2_blk[1]  = hdr_q[17];
    p2_blk[2]  = hdr_q[18];
    p2_blk[3]  = nonce;
    p2_blk[4]  = 32'h8000_0000;
    p2_blk[15] = 32'h0000_0280;
    p3_blk     = '0;
    p3_blk[7:0] = p2_q;
    p3_blk[8]  = 32'h8000_0000;
    p3_blk[15] = 32'h0000_0100;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      done       <= 1'b1;
      core_start <= 1'b0;
      core_h_in  <= '0;
      core_block <= '0;
      res_valid  <= 1'b0;
      res_nonce  <= '0;
      res_hash   <= '0;
      idx        <= '0;
      busy_seen  <= 1'b0;
      hdr_q      <= '0;
      base_q     <= '0;
      mid_q      <= '0;
      p2_q       <= '0;
`ifdef BTC_TARGET_STOP_EN
      target_q   <= '0;
      hit        <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            hdr_q  <= header;
            base_q <= nonce_base;
            idx    <= '0;
            done   <= 1'b0;
            state  <= MID_ST;
`ifdef BTC_TARGET_STOP_EN
            target_q <= target;
            hit      <= 1'b0;
`endif
          end
        end
        MID_ST: begin
          core_h_in  <= IV;
          core_block <= hdr_q[15:0];
          core_start <= 1'b1;
          busy_seen  <= 1'b0;
          state      <= MID_WT;
        end
        MID_WT: begin
          if (!core_done) busy_seen <= 1'b1;
          if (core_fin) begin
            mid_q <= core_digest;
            state <= P2_ST;
          end
        end
        P2_ST: begin
          core_h_in  <= mid_q;
          core_block <= p2_blk;
          core_start <= 1'b1;
          busy_seen  <= 1'b0;
          state      <= P2_WT;
        end
        P2_WT: begin
          if (!core_done) busy_seen <= 1'b1;
          if (core_fin) begin
            p2_q  <= core_digest;
            state <= P3_ST;
          end
        end
        P3_ST: begin
          core_h_in  <= IV;
          core_block <= p3_blk;
          core_start <= 1'b1;
          busy_seen  <= 1'b0;
          state      <= P3_WT;
        end
        P3_WT: begin
          if (!core_done) busy_seen <= 1'b1;
          if (core_fin) begin
            res_valid <= 1'b1;
            res_nonce <= nonce;
            res_hash  <= core_digest[0];
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            idx       <= idx + IW'(1);
`ifdef BTC_TARGET_STOP_EN
            if (below) hit <= 1'b1;
`endif
            if (last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= P2_ST;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_nonce_sched.sv
// tb_bitcoin_nonce_sched: random headers/nonces vs a queue-based flow model,
// with a behavioural simplified SHA-256 core answering core_start.
module tb_bitcoin_nonce_sched;

  localparam int N = 16;
`ifdef BTC_TARGET_STOP_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [18:0][31:0] hdr;
  logic [18:0][31:0] hdr_drv;
  logic [31:0]       base_drv;
  logic              core_start;
  logic [7:0][31:0]  core_h_in;
  logic [15:0][31:0] core_block;
  logic              core_done;
  logic [7:0][31:0]  core_digest;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_nonce;
  logic [31:0]       res_hash;
  logic              done;
`ifdef BTC_TARGET_STOP_EN
  logic [31:0]       target;
  logic              hit;
`endif

  int checks = 0;
  int errors = 0;
  int cs_cnt = 0;
  int res_cnt = 0;
  int exp_n = 0;
  bit exp_hit = 1'b0;
  logic [767:0] exp_calls[$];
  logic [63:0]  exp_res[$];
  logic [63:0]  mon_e;

  always #5 clk = ~clk;

  bitcoin_nonce_sched #(.NUM_NONCES(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .header      (hdr_drv),
    .nonce_base  (base_drv),
`ifdef BTC_TARGET_STOP_EN
    .target      (target),
    .hit         (hit),
`endif
    .core_start  (core_start),
    .core_h_in   (core_h_in),
    .core_block  (core_block),
    .core_done   (core_done),
    .core_digest (core_digest),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_nonce   (res_nonce),
    .res_hash    (res_hash),
    .done        (done)
  );

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // 16-round SHA-256-style compression with feed-forward
  function automatic logic [7:0][31:0] core_fn(input logic [7:0][31:0] hi,
                                               input logic [15:0][31:0] blk);
    logic [7:0][31:0] s;
    logic [7:0][31:0] o;
    logic [31:0] t1, t2, k;
    s = hi;
    for (int r = 0; r < 16; r++) begin
      k  = 32'h428a2f98 + 32'(r) * 32'h9e3779b9;
      t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + blk[r];
      t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) o[i] = hi[i] + s[i];
    return o;
  endfunction

  // Behavioural core: drops core_done, answers after a random latency
  initial begin : core_model
    logic [767:0] ec;
    logic [7:0][31:0] h;
    logic [15:0][31:0] b;
    core_done = 1'b1;
    core_digest = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        cs_cnt++;
        h = core_h_in;
        b = core_block;
        check("call_avail", 512'(exp_calls.size() != 0), 512'(1));
        if (exp_calls.size() != 0) begin
          ec = exp_calls.pop_front();
          check("core_h_in", 512'(h), 512'(ec[767:512]));
          check("core_block", 512'(b), ec[511:0]);
        end
        core_done = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        if (reset_n) begin
          check("blk_stable", 512'(core_block), 512'(b));
          check("hin_stable", 512'(core_h_in), 512'(h));
        end
        core_digest = core_fn(h, b);
        core_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      check("res_avail", 512'(exp_res.size() != 0), 512'(1));
      if (exp_res.size() != 0) begin
        mon_e = exp_res.pop_front();
        check("res_nonce", 512'(res_nonce), 512'(mon_e[63:32]));
        check("res_hash", 512'(res_hash), 512'(mon_e[31:0]));
      end
      res_cnt++;
    end
  end

  task automatic build_exp(input logic [31:0] base, input logic [31:0] tgt);
    logic [7:0][31:0] mid, d2, d3;
    logic [15:0][31:0] blk;
    logic [31:0] nn;
    exp_calls.delete();
    exp_res.delete();
    cs_cnt = 0;
    res_cnt = 0;
    exp_n = 0;
    exp_hit = 1'b0;
    for (int i = 0; i < 19; i++) hdr[i] = $urandom;
    blk = hdr[15:0];
    exp_calls.push_back({IV, blk});
    mid = core_fn(IV, blk);
    for (int n = 0; n < N && !exp_hit; n++) begin
      nn = base + 32'(n);
      blk = '0;
      blk[0] = hdr[16];
      blk[1] = hdr[17];
      blk[2] = hdr[18];
      blk[3] = nn;
      blk[4] = 32'h8000_0000;
      blk[15] = 32'h0000_0280;
      exp_calls.push_back({mid, blk});
      d2 = core_fn(mid, blk);
      blk = '0;
      blk[7:0] = d2;
      blk[8] = 32'h8000_0000;
      blk[15] = 32'h0000_0100;
      exp_calls.push_back({IV, blk});
      d3 = core_fn(IV, blk);
      exp_res.push_back({nn, d3[0]});
      exp_n++;
      if (HIT_EN && d3[0] < tgt) exp_hit = 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [31:0] tgt);
    @(posedge clk); #1;
    hdr_drv = hdr;
    base_drv = base;
`ifdef BTC_TARGET_STOP_EN
    target = tgt;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hdr_drv = ~hdr;
    base_drv = ~base;
`ifdef BTC_TARGET_STOP_EN
    target = ~tgt;
`endif
    @(negedge clk);
    check("done_drop", 512'(done), 512'(0));
  endtask

  // mode 0: ready=1, 1: random ready, 2: 10-cycle stall on first result
  task automatic do_run(input logic [31:0] base, input int mode,
                        input bit poke, input logic [31:0] tgt);
    int cyc;
    bit stalled, poked;
    logic [31:0] n0, h0;
    int cs0;
    build_exp(base, tgt);
    res_ready = (mode != 2);
    pulse_start(base, tgt);
    cyc = 0;
    stalled = 1'b0;
    poked = 1'b0;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      case (mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: res_ready = stalled;
      endcase
      if (mode == 2 && !stalled && res_valid) begin
        n0 = res_nonce;
        h0 = res_hash;
        cs0 = cs_cnt;
        check("bp_nonce", 512'(n0), 512'(base));
        repeat (10) begin
          @(negedge clk);
          check("bp_valid", 512'(res_valid), 512'(1));
          check("bp_nonce_hold", 512'(res_nonce), 512'(n0));
          check("bp_hash_hold", 512'(res_hash), 512'(h0));
        end
        check("bp_no_start", 512'(cs_cnt), 512'(cs0));
        @(posedge clk); #1;
        stalled = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_resume", 512'(res_valid), 512'(0));
      end
      if (poke && !poked && cs_cnt == 2 && !core_done) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    start = 1'b0;
    check("run_done", 512'(done), 512'(1));
    check("idle_valid", 512'(res_valid), 512'(0));
    check("res_count", 512'(res_cnt), 512'(exp_n));
    check("start_count", 512'(cs_cnt), 512'(1 + 2 * exp_n));
    if (poke) check("poke_fired", 512'(poked), 512'(1));
`ifdef BTC_TARGET_STOP_EN
    check("hit", 512'(hit), 512'(exp_hit));
`endif
  endtask

  task automatic mid_reset();
    int cyc;
    logic [31:0] b;
    b = $urandom;
    build_exp(b, 32'h0);
    res_ready = 1'b1;
    pulse_start(b, 32'h0);
    cyc = 0;
    while (!(cs_cnt == 3 && !core_done) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mr_reach_p3", 512'(cs_cnt), 512'(3));
    reset_n = 1'b0;
    #1;
    check("mr_done", 512'(done), 512'(1));
    check("mr_valid", 512'(res_valid), 512'(0));
    check("mr_block", 512'(core_block), 512'(0));
    check("mr_no_result", 512'(res_cnt), 512'(0));
    cyc = 0;
    while (!core_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mr_core_idle", 512'(core_done), 512'(1));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    hdr = '0;
    hdr_drv = '0;
    base_drv = '0;
`ifdef BTC_TARGET_STOP_EN
    target = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 512'(done), 512'(1));
    check("rst_valid", 512'(res_valid), 512'(0));
    check("rst_cstart", 512'(core_start), 512'(0));
    check("rst_nonce", 512'(res_nonce), 512'(0));
    check("rst_hash", 512'(res_hash), 512'(0));
    check("rst_hin", 512'(core_h_in), 512'(0));
    check("rst_block", 512'(core_block), 512'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    do_run(32'h0, 0, 1'b1, 32'h0);
    do_run(32'hFFFF_FFFE, 1, 1'b0, 32'h0);
    do_run($urandom, 2, 1'b0, 32'h0);
    mid_reset();
    do_run($urandom, 0, 1'b0, 32'h0);
`ifdef BTC_TARGET_STOP_EN
    do_run($urandom, 0, 1'b0, 32'hFFFF_FFFF);
    do_run($urandom, 1, 1'b0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
